// File: rtl/sisc_seq_ctrl_pkg.sv
// Shared definitions for the SISC multicycle sequencer: opcodes, FSM state
// encoding, ALU operation codes, status-bit positions and the strobe bundle.
package sisc_defs;

    typedef enum logic [3:0] {
        OP_NOOP  = 4'b0000,
        OP_ALU_R = 4'b0001,
        OP_ALU_I = 4'b0010,
        OP_LOD   = 4'b0011,
        OP_STR   = 4'b0100,
        OP_BRA   = 4'b0101,
        OP_BRR   = 4'b0110,
        OP_BNE   = 4'b0111,
        OP_HLT   = 4'b1111
    } opcode_e;

    typedef enum logic [2:0] {
        S_START0    = 3'd0,
        S_START1    = 3'd1,
        S_FETCH     = 3'd2,
        S_DECODE    = 3'd3,
        S_EXECUTE   = 3'd4,
        S_MEM       = 3'd5,
        S_WRITEBACK = 3'd6,
        S_HALT      = 3'd7
    } state_e;

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_RR   = 2'b01;
    localparam logic [1:0] ALU_ADDR = 2'b10;

    // statreg is {C,V,N,Z}
    localparam int STAT_Z = 0;
    localparam int STAT_N = 1;
    localparam int STAT_V = 2;
    localparam int STAT_C = 3;

    typedef struct packed {
        logic       ir_load;
        logic       pc_write;
        logic       pc_sel;
        logic       br_sel;
        logic       rf_we;
        logic [1:0] alu_op;
        logic       wb_sel;
        logic       rd_sel;
        logic       dm_we;
        logic       stat_en;
        logic       halted;
    } ctrl_t;

endpackage

// File: rtl/sisc_seq_ctrl_if.sv
// Sequencer <-> datapath bundle: IR/statreg fields in, control strobes and
// retired-instruction count out.
interface sisc_seq_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [3:0]       opcode;
    logic [3:0]       mm;
    logic [3:0]       stat;
    logic             ir_load;
    logic             pc_write;
    logic             pc_sel;
    logic             br_sel;
    logic             rf_we;
    logic [1:0]       alu_op;
    logic             wb_sel;
    logic             rd_sel;
    logic             dm_we;
    logic             stat_en;
    logic             halted;
    logic [CNT_W-1:0] icount;

    modport master (
        input  opcode, mm, stat,
        output ir_load, pc_write, pc_sel, br_sel, rf_we, alu_op,
               wb_sel, rd_sel, dm_we, stat_en, halted, icount
    );

    modport slave (
        output opcode, mm, stat,
        input  ir_load, pc_write, pc_sel, br_sel, rf_we, alu_op,
               wb_sel, rd_sel, dm_we, stat_en, halted, icount
    );
endinterface

// File: rtl/sisc_seq_ctrl_br_eval.sv
// Conditional-branch evaluator: compares the mm condition mask against the
// live statreg value for BRA/BRR/BNE.
module sisc_br_eval
    import sisc_defs::*;
(
    input  logic [3:0] opcode,
    input  logic [3:0] mm,
    input  logic [3:0] stat,
    output logic       taken
);

    logic w_hit;

    assign w_hit = |(mm & stat);

    always_comb begin
        taken = 1'b0;
        case (opcode)
            OP_BRA, OP_BRR: taken = (mm == 4'b0000) || w_hit;
            OP_BNE:         taken = !w_hit;
            default:        taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/sisc_seq_ctrl.sv
// SISC multicycle sequencer: walks FETCH/DECODE/EXECUTE/MEM/WRITEBACK and
// decodes every datapath strobe from the registered state plus IR/statreg.
module sisc_seq_ctrl
    import sisc_defs::*;
#(
    parameter int CNT_W = 16
) (
    input  logic           clk,
    input  logic           rst_f,
    sisc_seq_ctrl_if.master bus
);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_icount;
    ctrl_t            w_ctl;
    logic             w_taken;

    sisc_br_eval u_br_eval (
        .opcode (bus.opcode),
        .mm     (bus.mm),
        .stat   (bus.stat),
        .taken  (w_taken)
    );

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            r_state <= S_START0;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Retirement is the WRITEBACK -> FETCH edge; HLT never reaches WRITEBACK.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            r_icount <= '0;
        end else if (r_state == S_WRITEBACK) begin
            r_icount <= r_icount + CNT_W'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ctl       = '0;
        case (r_state)
            S_START0: w_state_nxt = S_START1;
            S_START1: w_state_nxt = S_FETCH;
            S_FETCH: begin
                w_ctl.ir_load  = 1'b1;
                w_ctl.pc_write = 1'b1;
                w_state_nxt    = S_DECODE;
            end
            S_DECODE: begin
                w_state_nxt = (bus.opcode == OP_HLT) ? S_HALT : S_EXECUTE;
            end
            S_EXECUTE: begin
                w_state_nxt = S_MEM;
                case (bus.opcode)
                    OP_ALU_R: begin
                        w_ctl.alu_op  = ALU_RR;
                        w_ctl.stat_en = 1'b1;
                    end
                    OP_ALU_I: begin
                        w_ctl.alu_op  = ALU_PASS;
                        w_ctl.stat_en = 1'b1;
                    end
                    OP_LOD, OP_STR: w_ctl.alu_op = ALU_ADDR;
                    OP_BRA, OP_BRR, OP_BNE: begin
                        w_ctl.pc_write = w_taken;
                        w_ctl.pc_sel   = w_taken;
                        w_ctl.br_sel   = w_taken && (bus.opcode == OP_BRR);
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                w_state_nxt = S_WRITEBACK;
                if (bus.opcode == OP_STR) begin
                    w_ctl.dm_we  = 1'b1;
                    w_ctl.rd_sel = 1'b1;
                end else if (bus.opcode == OP_LOD) begin
                    w_ctl.alu_op = ALU_ADDR;
                end
            end
            S_WRITEBACK: begin
                w_state_nxt = S_FETCH;
                case (bus.opcode)
                    OP_ALU_R: begin
                        w_ctl.rf_we  = 1'b1;
                        w_ctl.alu_op = ALU_RR;
                    end
                    OP_ALU_I: w_ctl.rf_we = 1'b1;
                    OP_LOD: begin
                        w_ctl.rf_we  = 1'b1;
                        w_ctl.wb_sel = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_HALT: begin
                w_ctl.halted = 1'b1;
                w_state_nxt  = S_HALT;
            end
            default: w_state_nxt = S_START0;
        endcase
    end

    assign bus.ir_load  = w_ctl.ir_load;
    assign bus.pc_write = w_ctl.pc_write;
    assign bus.pc_sel   = w_ctl.pc_sel;
    assign bus.br_sel   = w_ctl.br_sel;
    assign bus.rf_we    = w_ctl.rf_we;
    assign bus.alu_op   = w_ctl.alu_op;
    assign bus.wb_sel   = w_ctl.wb_sel;
    assign bus.rd_sel   = w_ctl.rd_sel;
    assign bus.dm_we    = w_ctl.dm_we;
    assign bus.stat_en  = w_ctl.stat_en;
    assign bus.halted   = w_ctl.halted;
    assign bus.icount   = r_icount;

endmodule

// File: tb/tb_sisc_seq_ctrl.sv
// Scoreboard bench for sisc_seq_ctrl: the driver queues hand-written per-cycle
// strobe/icount expectations, a monitor pops and compares them.
module tb_sisc_seq_ctrl;
    import sisc_defs::*;

    localparam int CW = 4;

    // strobe vector order: ir_load pc_write pc_sel br_sel | rf_we alu_op[1:0] wb_sel | rd_sel dm_we stat_en halted
    localparam logic [11:0] Z      = 12'b0000_0000_0000;
    localparam logic [11:0] F      = 12'b1100_0000_0000;
    localparam logic [11:0] H      = 12'b0000_0000_0001;
    localparam logic [11:0] AR_EX  = 12'b0000_0010_0010;
    localparam logic [11:0] AR_WB  = 12'b0000_1010_0000;
    localparam logic [11:0] AI_EX  = 12'b0000_0000_0010;
    localparam logic [11:0] AI_WB  = 12'b0000_1000_0000;
    localparam logic [11:0] ADR    = 12'b0000_0100_0000;
    localparam logic [11:0] LOD_WB = 12'b0000_1001_0000;
    localparam logic [11:0] STR_MM = 12'b0000_0000_1100;
    localparam logic [11:0] BR_ABS = 12'b0110_0000_0000;
    localparam logic [11:0] BR_REL = 12'b0111_0000_0000;

    typedef struct packed {
        logic [11:0]   ctl;
        logic [CW-1:0] cnt;
        logic [15:0]   tag;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_f = 1'b0;
    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   tag      = 0;
    logic [CW-1:0] exp_cnt = '0;

    sisc_seq_ctrl_if #(.CNT_W(CW)) bus ();
    sisc_seq_ctrl #(.CNT_W(CW)) dut (.clk(clk), .rst_f(rst_f), .bus(bus));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [11:0] c);
        q.push_back('{ctl: c, cnt: exp_cnt, tag: 16'(tag)});
        tag++;
    endtask

    task automatic run(input logic [3:0] op, input logic [3:0] mm, input logic [3:0] st,
                       input logic [11:0] ex, input logic [11:0] mem, input logic [11:0] wb);
        step(); bus.opcode = op; bus.mm = mm; bus.stat = st; push(F);
        step(); push(Z);
        step(); push(ex);
        step(); push(mem);
        step(); push(wb);
        exp_cnt = exp_cnt + 1'b1;
    endtask

    // Monitor also wakes on an asynchronous reset assertion to see strobes drop.
    initial begin
        exp_t e;
        logic [11:0] act;
        forever begin
            @(negedge clk or negedge rst_f);
            #1;
            if (q.size() > 0) begin
                e   = q.pop_front();
                act = {bus.ir_load, bus.pc_write, bus.pc_sel, bus.br_sel, bus.rf_we, bus.alu_op,
                       bus.wb_sel, bus.rd_sel, bus.dm_we, bus.stat_en, bus.halted};
                checks++;
                if (act !== e.ctl) begin
                    failures++;
                    $display("FAIL strobes#%0d act=%b exp=%b", e.tag, act, e.ctl);
                end
                checks++;
                if (bus.icount !== e.cnt) begin
                    failures++;
                    $display("FAIL icount#%0d act=%0d exp=%0d", e.tag, bus.icount, e.cnt);
                end
            end
        end
    end

    initial begin
        int budget;
        bus.opcode = OP_NOOP; bus.mm = 4'h0; bus.stat = 4'h0;
        // reset held, then the two idle start cycles
        step(); push(Z);
        step(); rst_f = 1'b1; push(Z);
        step(); push(Z);

        repeat (3) run(OP_NOOP, 4'h0, 4'h0, Z, Z, Z);
        run(OP_ALU_R, 4'b0001, 4'h0, AR_EX, Z, AR_WB);
        run(OP_ALU_I, 4'b0011, 4'h0, AI_EX, Z, AI_WB);
        run(OP_BRA, 4'b0001, 4'b0001, BR_ABS, Z, Z);
        run(OP_BRA, 4'b0001, 4'b0000, Z, Z, Z);
        run(OP_BRA, 4'b0000, 4'b0000, BR_ABS, Z, Z);
        run(OP_BRR, 4'b0010, 4'b0010, BR_REL, Z, Z);
        run(OP_BNE, 4'b0001, 4'b0000, BR_ABS, Z, Z);
        run(OP_BNE, 4'b0001, 4'b0001, Z, Z, Z);
        run(OP_LOD, 4'h0, 4'h0, ADR, ADR, LOD_WB);
        run(OP_STR, 4'h0, 4'h0, ADR, STR_MM, Z);
        run(4'b1010, 4'h0, 4'h0, Z, Z, Z);

        // HLT: count stays at 14 while halted
        step(); bus.opcode = OP_HLT; push(F);
        step(); push(Z);
        repeat (22) begin step(); push(H); end
        step(); exp_cnt = '0; push(Z); rst_f = 1'b0;
        step(); rst_f = 1'b1; bus.opcode = OP_NOOP; push(Z);
        step(); push(Z);

        // 16 retirements wrap the 4-bit counter to 0
        repeat (16) run(OP_NOOP, 4'h0, 4'h0, Z, Z, Z);

        // reset in the middle of ALU_R WRITEBACK: rf_we must fall at once
        step(); bus.opcode = OP_ALU_R; bus.mm = 4'b0001; push(F);
        step(); push(Z);
        step(); push(AR_EX);
        step(); push(Z);
        step(); push(AR_WB);
        @(negedge clk); #2;
        exp_cnt = '0; push(Z); rst_f = 1'b0;
        step(); rst_f = 1'b1; push(Z);
        step(); push(Z);
        run(OP_NOOP, 4'h0, 4'h0, Z, Z, Z);

        budget = 0;
        while (q.size() > 0 && budget < 10) begin
            @(posedge clk);
            budget++;
        end
        if (q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain left=%0d exp=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sisc_seq_ctrl.md
Name: sisc_seq_ctrl

Overview:
Multicycle instruction sequencer for the SISC part-two datapath. It steps each instruction through fetch, decode, execute, memory and writeback, and issues every datapath control strobe: PC, IR, register file, ALU, writeback mux and data memory. It also evaluates conditional branches against the status register and counts retired instructions. It sits between the IR/statreg outputs and the PC, IR, rf, alu, mux4/mux32 and data-memory enables.

Parameters:
CNT_W, 16, width of retired-instruction counter

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_f  in  1  asynchronous active-low reset
opcode  in  4  ir[31:28]; valid from DECODE onward
mm  in  4  ir[27:24]; ALU function / branch condition mask
stat  in  4  statreg output {C,V,N,Z} = bits [3:0]
ir_load  out  1  load IR from instruction memory
pc_write  out  1  update PC
pc_sel  out  1  0 = PC+1, 1 = branch target
br_sel  out  1  0 = absolute target (ir[15:0]), 1 = PC-relative target
rf_we  out  1  register file write enable
alu_op  out  2  00 pass/add-imm, 01 reg-reg arithmetic (mm selects function), 10 address calc, 11 unused
wb_sel  out  1  0 = ALU result, 1 = data memory
rd_sel  out  1  0 = rt (ir[15:12]), 1 = rd (ir[23:20]) as second read address
dm_we  out  1  data memory write enable
stat_en  out  1  enable statreg update
halted  out  1  high in HALT state
icount  out  CNT_W  retired-instruction count

Behaviour:
- Reset (rst_f low, asynchronous): state = START0, icount = 0, all strobes 0, halted = 0.
- States: START0 -> START1 -> FETCH -> DECODE -> EXECUTE -> MEM -> WRITEBACK -> FETCH. HALT is absorbing and is left only by reset.
- START0 and START1 are idle cycles with all outputs 0, giving the memories one settle cycle after reset.
- Outputs are a combinational decode of the registered state and the opcode/mm/stat inputs. No output depends on anything other than the current state and those inputs.
- FETCH: ir_load = 1, pc_write = 1, pc_sel = 0 (PC <= PC+1).
- DECODE: no strobes. If opcode = HLT (1111), next state = HALT; otherwise EXECUTE.
- EXECUTE:
  - ALU_R (0001): alu_op = 01, stat_en = 1.
  - ALU_I (0010): alu_op = 00, stat_en = 1.
  - LOD (0011) / STR (0100): alu_op = 10.
  - BRA (0101), BRR (0110), BNE (0111): pc_write = 1 and pc_sel = 1 only when taken; br_sel = 1 for BRR.
- Branch taken rules:
  - BRA/BRR: taken if mm = 0000, or if (mm & stat) != 0.
  - BNE: taken if (mm & stat) = 0.
  - Uses the stat value present in the EXECUTE cycle.
- MEM: STR drives dm_we = 1 and rd_sel = 1. LOD holds alu_op = 10.
- WRITEBACK:
  - ALU_R: rf_we = 1, wb_sel = 0, alu_op = 01.
  - ALU_I: rf_we = 1, wb_sel = 0, alu_op = 00.
  - LOD: rf_we = 1, wb_sel = 1.
  - NOOP (0000), STR and branches: no write.
- icount increments by 1 on every WRITEBACK -> FETCH transition. It wraps from 2^CNT_W-1 to 0. HLT is not counted.
- Undefined opcodes (1000-1110) behave as NOOP: 5 cycles, counted, no strobes beyond FETCH.
- Latency: every non-HLT instruction takes exactly 5 cycles, FETCH to WRITEBACK.
- Reset asserted mid-instruction: returns to START0 immediately. Strobes drop in the same cycle, so no partial write occurs after the asynchronous assertion.
- HALT: halted = 1, all strobes 0, icount frozen.

Decomposition:
- Shared package sisc_defs:
  - opcode constants (NOOP, ALU_R, ALU_I, LOD, STR, BRA, BRR, BNE, HLT);
  - state encoding (3-bit, START0 = 0 ... HALT = 7);
  - alu_op codes;
  - stat bit indices.
- One combinational sub-module, sisc_br_eval: inputs opcode, mm, stat; output taken.

Test Plan:
- Reset release, then NOOP stream -> 2 idle cycles, ir_load pulses every 5 cycles starting cycle 3; icount = 3 after 15 cycles past START1.
- ALU_R with mm = 0001 -> alu_op = 01 with stat_en = 1 in EXECUTE; rf_we = 1, wb_sel = 0 in WRITEBACK; rf_we = 0 in all other states.
- BRA mm = 0001: with stat = 0001 -> pc_write = 1, pc_sel = 1, br_sel = 0 in EXECUTE. With stat = 0000 -> pc_write = 0 in EXECUTE. BNE mm = 0001, stat = 0000 -> taken.
- LOD then STR -> LOD: wb_sel = 1 and rf_we = 1 in WRITEBACK. STR: dm_we = 1 and rd_sel = 1 in MEM only, rf_we never asserted.
- HLT opcode -> halted = 1 from the cycle after DECODE, strobes 0 for 20+ cycles, icount unchanged. A rst_f pulse returns to START0 and clears icount.
- Preload icount near wrap (CNT_W = 4, 15 instructions), then run one more -> icount = 0. rst_f asserted mid-WRITEBACK -> rf_we drops immediately.
